// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block: active-low segment
// patterns (gfedcba), capture FSM states and digit index constants.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] VAL_BLANK = 4'hF;

  localparam logic [1:0] DIG_ONES      = 2'd0;
  localparam logic [1:0] DIG_TENS      = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS  = 2'd2;
  localparam logic [1:0] DIG_THOUSANDS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Exactly one active-low anode enable asserted.
  function automatic logic is_single(input logic [3:0] an);
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: is_single = 1'b1;
      default:                            is_single = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] single_idx(input logic [3:0] an);
    case (an)
      4'b1101: single_idx = DIG_TENS;
      4'b1011: single_idx = DIG_HUNDREDS;
      4'b0111: single_idx = DIG_THOUSANDS;
      default: single_idx = DIG_ONES;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to BCD decoder; blank decodes to 4'hF,
// anything outside the eleven known patterns raises invalid.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       invalid
);

  // Pattern lookup
  always_comb begin
    value   = 4'h0;
    invalid = 1'b0;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: value = VAL_BLANK;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures the digits shown on a multiplexed active-low 4-digit display.
// Optional feature macro SEG7_CAPTURE_DP_EN adds the per-digit dp output.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CNT    = 4,
  parameter int unsigned DIGIT_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] anode,
  input  logic [7:0] out,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic [3:0] digit_valid,
  output logic       frame_valid,
  output logic       seg_err
`ifdef SEG7_CAPTURE_DP_EN
  ,
  output logic [3:0] dp
`endif
);

  localparam logic [7:0]  STABLE_C  = 8'(STABLE_CNT);
  localparam logic [23:0] TIMEOUT_C = 24'(DIGIT_TIMEOUT);

  logic [3:0]  an_s1_q, an_s1_d, an_q, an_d;
  logic [7:0]  out_s1_q, out_s1_d, out_q, out_d;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] ref_q, ref_d;
  logic [10:0] sample_s;
  logic        single_s, commit_s;
  logic [1:0]  commit_idx_s;
  logic [3:0]  dec_value_s;
  logic        dec_invalid_s;
  logic [3:0]  digit_q [4];
  logic [3:0]  digit_d [4];
  logic [23:0] to_q [4];
  logic [23:0] to_d [4];
  logic [3:0]  valid_q, valid_d, mask_q, mask_d;
  logic        frame_q, frame_d, err_q, err_d;
`ifdef SEG7_CAPTURE_DP_EN
  logic [3:0]  dp_q, dp_d;
`else
  logic        dp_unused_s;
  assign dp_unused_s = out_q[7];
`endif

  assign sample_s     = {an_q, out_q[6:0]};
  assign single_s     = is_single(an_q);
  assign commit_idx_s = single_idx(an_q);

  seg7_decode u_decode (
    .seg     (out_q[6:0]),
    .value   (dec_value_s),
    .invalid (dec_invalid_s)
  );

  // Two-stage input synchronizer
  always_comb begin
    an_s1_d  = anode;
    an_d     = an_s1_q;
    out_s1_d = out;
    out_d    = out_s1_q;
  end

  // Capture FSM: track stability of the current sample and flag the commit edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (single_s) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
          ref_d   = sample_s;
        end else begin
          cnt_d = 8'd0;
        end
      end
      ST_SETTLE, ST_LOCKED: begin
        if (!single_s) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (sample_s != ref_q) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
          ref_d   = sample_s;
        end else if (state_q == ST_SETTLE) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // A hold that has just reached the threshold commits on this very edge.
    if (state_d == ST_SETTLE && cnt_d >= STABLE_C) begin
      state_d  = ST_LOCKED;
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Digit registers, freshness timeouts and frame mask
  always_comb begin
    digit_d = digit_q;
    to_d    = to_q;
    valid_d = valid_q;
    mask_d  = (mask_q == 4'hF) ? 4'h0 : mask_q;
    frame_d = (mask_q == 4'hF);
    err_d   = commit_s && dec_invalid_s;
`ifdef SEG7_CAPTURE_DP_EN
    dp_d    = dp_q;
`endif
    for (int i = 0; i < 4; i++) begin
      if (commit_s && !dec_invalid_s && commit_idx_s == 2'(i)) begin
        digit_d[i] = dec_value_s;
        valid_d[i] = 1'b1;
        to_d[i]    = 24'd0;
        mask_d[i]  = 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
        dp_d[i]    = ~out_q[7];
`endif
      end else begin
        to_d[i]    = (to_q[i] == TIMEOUT_C) ? to_q[i] : to_q[i] + 24'd1;
        valid_d[i] = (to_d[i] == TIMEOUT_C) ? 1'b0 : valid_q[i];
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_s1_q  <= 4'hF;
      an_q     <= 4'hF;
      out_s1_q <= 8'hFF;
      out_q    <= 8'hFF;
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      ref_q    <= 11'd0;
      valid_q  <= 4'h0;
      mask_q   <= 4'h0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= 4'h0;
        to_q[i]    <= 24'd0;
      end
`ifdef SEG7_CAPTURE_DP_EN
      dp_q     <= 4'h0;
`endif
    end else begin
      an_s1_q  <= an_s1_d;
      an_q     <= an_d;
      out_s1_q <= out_s1_d;
      out_q    <= out_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= digit_d[i];
        to_q[i]    <= to_d[i];
      end
`ifdef SEG7_CAPTURE_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign ones        = digit_q[DIG_ONES];
  assign tens        = digit_q[DIG_TENS];
  assign hundreds    = digit_q[DIG_HUNDREDS];
  assign thousands   = digit_q[DIG_THOUSANDS];
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign seg_err     = err_q;
`ifdef SEG7_CAPTURE_DP_EN
  assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture (STABLE_CNT=4, DIGIT_TIMEOUT=16).
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] anode;
  logic [7:0] out;
  logic [3:0] ones, tens, hundreds, thousands, digit_valid;
  logic       frame_valid, seg_err;
`ifdef SEG7_CAPTURE_DP_EN
  logic [3:0] dp;
`endif

  int n_vec    = 0;
  int n_err    = 0;
  int n_frame  = 0;
  int n_segerr = 0;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CNT(4), .DIGIT_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .anode       (anode),
    .out         (out),
    .ones        (ones),
    .tens        (tens),
    .hundreds    (hundreds),
    .thousands   (thousands),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .seg_err     (seg_err)
`ifdef SEG7_CAPTURE_DP_EN
    ,
    .dp          (dp)
`endif
  );

  // Pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (frame_valid) n_frame++;
    if (seg_err)     n_segerr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] scan_out [4] = '{8'hF9, 8'hB0, 8'h92, 8'hF8};

  initial begin
    reset = 1'b0;
    anode = 4'hF;
    out   = 8'hFF;
    step(3);
    check_eq("rst_ones",   ones,        32'h0);
    check_eq("rst_thou",   thousands,   32'h0);
    check_eq("rst_valid",  digit_valid, 32'h0);
    check_eq("rst_frame",  frame_valid, 32'h0);
    check_eq("rst_segerr", seg_err,     32'h0);

    // First capture: '0' on ones, commit 6 cycles after the pins change
    reset = 1'b1;
    anode = 4'b1110;
    out   = 8'hC0;
    step(5);
    check_eq("lat_early_valid", digit_valid, 32'h0);
    step(1);
    check_eq("lat_valid",  digit_valid, 32'h1);
    check_eq("lat_ones",   ones,        32'h0);
    check_eq("lat_segerr", n_segerr,    32'd0);

    // Scan 1/3/5/7 across the four digits
    n_frame = 0;
    for (int k = 0; k < 3; k++) begin
      anode = scan_an[k];
      out   = scan_out[k];
      step(8);
    end
    anode = scan_an[3];
    out   = scan_out[3];
    step(6);
    check_eq("scan_thou",       thousands,   32'd7);
    check_eq("scan_frame_pre",  frame_valid, 32'h0);
    step(1);
    check_eq("scan_frame_hit",  frame_valid, 32'h1);
    step(1);
    check_eq("scan_frame_post", frame_valid, 32'h0);
    check_eq("scan_ones",       ones,        32'd1);
    check_eq("scan_tens",       tens,        32'd3);
    check_eq("scan_hund",       hundreds,    32'd5);
    check_eq("scan_nframe",     n_frame,     32'd1);
    check_eq("scan_valid",      digit_valid, 32'b1100);

    // Undecodable pattern on ones
    anode = 4'b1110;
    out   = 8'hFE;
    step(8);
    check_eq("bad_segerr", n_segerr,    32'd1);
    check_eq("bad_ones",   ones,        32'd1);
    check_eq("bad_valid",  digit_valid, 32'b1000);

    // Multi-anode and no-anode samples never commit
    anode = 4'b1100;
    out   = 8'hC0;
    step(8);
    anode = 4'b1111;
    step(8);
    check_eq("none_ones",   ones,        32'd1);
    check_eq("none_tens",   tens,        32'd3);
    check_eq("none_valid",  digit_valid, 32'h0);
    check_eq("none_segerr", n_segerr,    32'd1);
    check_eq("none_frame",  n_frame,     32'd1);

    // Pattern toggling faster than the stability window, ending on C0
    anode = 4'b1110;
    for (int k = 0; k < 7; k++) begin
      out = (k % 2 == 0) ? 8'hC0 : 8'hF9;
      step(2);
    end
    check_eq("tog_valid", digit_valid, 32'h0);
    check_eq("tog_ones",  ones,        32'd1);
    out = 8'hF9;
    step(5);
    check_eq("hold_early_valid", digit_valid, 32'h0);
    step(1);
    check_eq("hold_valid", digit_valid, 32'h1);
    check_eq("hold_ones",  ones,        32'd1);

    // Freshness timeout 16 cycles after the commit
    anode = 4'b1111;
    step(15);
    check_eq("to_before", digit_valid, 32'h1);
    step(1);
    check_eq("to_after",  digit_valid, 32'h0);
    check_eq("to_ones",   ones,        32'd1);

    // Reset in the middle of a settle discards the partial capture
    anode = 4'b1110;
    out   = 8'hA4;
    step(4);
    reset = 1'b0;
    step(1);
    check_eq("mid_rst_ones",  ones,        32'h0);
    check_eq("mid_rst_valid", digit_valid, 32'h0);
    anode = 4'b1111;
    out   = 8'hFF;
    step(1);
    reset = 1'b1;
    step(8);
    check_eq("post_rst_ones",  ones,        32'h0);
    check_eq("post_rst_valid", digit_valid, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4: consecutive identical synchronized samples required before a digit commits; legal range 1..255.
REQ-002 SHALL have parameter DIGIT_TIMEOUT, default 1_000_000: clk cycles without a commit before a digit's valid bit clears; legal range 2..2^24-1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 anode  input  4  multiplexed digit enables, active-low; anode[0]=ones, anode[3]=thousands.
REQ-006 out  input  8  segment lines, active-low; out[0..6]=a..g, out[7]=dp.
REQ-007 ones, tens, hundreds, thousands  output  4 each  captured BCD digit values.
REQ-008 digit_valid  output  4  bit i set while digit i holds a fresh capture; bit order matches anode.
REQ-009 frame_valid  output  1  one-cycle pulse when all four digits have committed since the previous pulse.
REQ-010 seg_err  output  1  one-cycle pulse when a stable pattern fails to decode.

Function
REQ-011 anode and out SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Sample is "single" when exactly one synchronized anode bit is 0; all other anode values SHALL be "none".
REQ-013 FSM states SHALL be IDLE, SETTLE, LOCKED; reset state IDLE.
REQ-014 IDLE -> SETTLE on a single sample; the stability counter loads 1 and {anode,out[6:0]} is latched as reference.
REQ-015 SETTLE: a sample equal to the reference increments the counter; a differing single sample reloads the reference with counter=1; none -> IDLE.
REQ-016 SETTLE -> LOCKED when the counter reaches STABLE_CNT; commit occurs on that same edge.
REQ-017 LOCKED: any sample differing from the reference -> SETTLE (reloaded) if single, else IDLE; no second commit from the same hold.
REQ-018 Commit latency SHALL be exactly 2 + STABLE_CNT cycles from a change at the pins to the output register update.
REQ-019 Decode: the ten standard 0-9 patterns yield 0-9; all-segments-off yields 4'hF (blank); out[7] SHALL be ignored for decode.
REQ-020 Valid decode: the digit register is written, its digit_valid bit set, and its timeout counter cleared.
REQ-021 Invalid pattern: seg_err pulses, the digit register and valid bit are unchanged, and the FSM still enters LOCKED.
REQ-022 Per-digit timeout counter saturates; on reaching DIGIT_TIMEOUT it clears digit_valid[i] only, and the value is held.
REQ-023 A 4-bit frame mask sets on each valid commit; when the mask is all ones, frame_valid pulses on the next cycle and the mask clears.
REQ-024 A commit landing in the same cycle as the frame_valid pulse SHALL set its bit in the cleared mask, counting toward the next frame.

Reset
REQ-025 While reset=0: FSM IDLE, all counters and masks 0, digit outputs 4'h0, digit_valid 0, frame_valid 0, seg_err 0, synchronizers all-ones (inactive).
REQ-026 Reset asserted mid-SETTLE SHALL discard the partial capture with no commit after release.

Configuration
REQ-027 Macro SEG7_CAPTURE_DP_EN defined: extra output dp (4 bits) SHALL exist, with dp[i] = inverted out[7] latched at each valid commit of digit i (reset 0).
REQ-028 Macro SEG7_CAPTURE_DP_EN absent: the dp port and its registers SHALL not exist; all other behaviour is identical.

Structure
REQ-029 Package seg7_pkg SHALL hold the active-low segment pattern constants for 0-9 and blank, the FSM state typedef, and the digit index constants.
REQ-030 Combinational sub-module seg7_decode (7-bit pattern in, 4-bit value and invalid flag out) SHALL be instantiated once.

Verification
REQ-031 Reset release, anode=4'b1110, out=8'hC0 held 6 cycles -> ones=0, digit_valid=4'b0001 at cycle 6, seg_err=0.
REQ-032 Scan anode 1110/1101/1011/0111 with out F9/B0/92/F8, 8 cycles each -> ones=1, tens=3, hundreds=5, thousands=7, one frame_valid pulse after the thousands commit.
REQ-033 anode=4'b1110, out=8'hFE held 8 cycles -> single seg_err pulse, ones and digit_valid unchanged.
REQ-034 anode=4'b1100 or 4'b1111 with any out -> no commit, FSM stays IDLE.
REQ-035 out toggles C0/F9 every 2 cycles on anode=4'b1110 with STABLE_CNT=4 -> no commit; a later hold of F9 for 6 cycles -> ones=1.
REQ-036 DIGIT_TIMEOUT=16, commit ones then hold anode=4'b1111 -> digit_valid[0] clears exactly 16 cycles after the commit and ones stays 1.
